// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls and flushes for exceptions, cache misses, the divider, load-use and mispredicts.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rtE,
    input  logic        mem_readE,
    input  logic        mispredictE,
    input  logic        div_startE,
    input  logic        except_M,
    input  logic        i_stall,
    input  logic        d_stall,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        stallW,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        pc_redirect,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {IDLE, EXC_WAIT, EXC_FLUSH} state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

    state_t     state_reg, state_next;
    logic [5:0] div_cnt_reg, div_cnt_next;
    logic       done_hold_reg, done_hold_next;
    logic       pend_reg, pend_next;

    logic cache_stall;
    logic exc_flush;
    logic exc_wait;
    logic global_stall;
    logic div_busy_int;
    logic div_done_int;
    logic load_use;
    logic div_start;

    assign cache_stall  = i_stall | d_stall;
    assign exc_flush    = (state_reg == EXC_FLUSH) ||
                          ((state_reg == IDLE) && except_M && !cache_stall);
    assign exc_wait     = (state_reg == EXC_WAIT) ||
                          ((state_reg == IDLE) && except_M && cache_stall);
    assign global_stall = cache_stall || (state_reg == EXC_WAIT);
    // The stall is released on the final count so E occupancy matches DIV_CYCLES.
    assign div_busy_int = div_cnt_reg > 6'd1;
    assign div_done_int = div_cnt_reg == 6'd1;
    assign load_use     = mem_readE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
    assign div_start    = div_startE && (div_cnt_reg == 6'd0) && !done_hold_reg &&
                          (state_reg == IDLE) && !except_M;

    // Exception FSM: state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Exception FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (except_M && cache_stall) state_next = EXC_WAIT;
            EXC_WAIT:  if (!cache_stall) state_next = EXC_FLUSH;
            EXC_FLUSH: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Exception FSM and hazard outputs, highest priority first
    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        stallW      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushM      = 1'b0;
        flushW      = 1'b0;
        pc_redirect = 1'b0;
        if (!resetn) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (exc_flush) begin
            flushD      = 1'b1;
            flushE      = 1'b1;
            flushM      = 1'b1;
            flushW      = 1'b1;
            pc_redirect = 1'b1;
        end else if (exc_wait || cache_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
        end else begin
            if (div_busy_int) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
            // Only the wrong-path F instruction dies; a stalled delay slot defers the kill.
            if (!div_busy_int && !load_use && (mispredictE || pend_reg)) begin
                flushD = 1'b1;
            end
        end
    end

    assign div_busy = resetn & div_busy_int;
    assign div_done = resetn & div_done_int;

    always_comb begin
        div_cnt_next   = div_cnt_reg;
        done_hold_next = done_hold_reg;
        pend_next      = pend_reg;
        if (exc_flush) begin
            div_cnt_next   = 6'd0;
            done_hold_next = 1'b0;
            pend_next      = 1'b0;
        end else begin
            if (div_start) begin
                div_cnt_next = DIV_LOAD;
            end else if ((div_cnt_reg != 6'd0) && !global_stall) begin
                div_cnt_next = div_cnt_reg - 6'd1;
            end
            // Set wins over clear so a still-asserted div_startE cannot restart on the next cycle.
            if (div_done_int) begin
                done_hold_next = 1'b1;
            end else if (!stallE) begin
                done_hold_next = 1'b0;
            end
            pend_next = stallD ? (pend_reg | mispredictE) : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt_reg   <= 6'd0;
            done_hold_reg <= 1'b0;
            pend_reg      <= 1'b0;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            done_hold_reg <= done_hold_next;
            pend_reg      <= pend_next;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [1:0] perf_inc;
    assign perf_inc = {flushD | exc_flush, stallF};

    // Index 0 counts stalled fetch cycles, index 1 counts D-stage kills; both wrap freely.
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (!resetn) begin
                cnt_reg <= 32'd0;
            end else if (perf_inc[gi]) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = g_perf[0].cnt_reg;
    assign perf_flush_cnt = g_perf[1].cnt_reg;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl with a scoreboard queue of expected output vectors.
// Packed output order: stallF..W, flushD..W, pc_redirect, div_busy, div_done.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  rsD, rtD, rtE;
    logic        mem_readE, mispredictE, div_startE, except_M, i_stall, d_stall;
    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushD, flushE, flushM, flushW;
    logic        pc_redirect, div_busy, div_done;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    hazard_ctrl #(.DIV_CYCLES(32)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .rtE(rtE),
        .mem_readE(mem_readE), .mispredictE(mispredictE), .div_startE(div_startE),
        .except_M(except_M), .i_stall(i_stall), .d_stall(d_stall),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .pc_redirect(pc_redirect), .div_busy(div_busy), .div_done(div_done),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] E_NONE  = 12'b000000000000;
    localparam logic [11:0] E_RST   = 12'b000001111000;
    localparam logic [11:0] E_STALL = 12'b111110000000;
    localparam logic [11:0] E_EXC   = 12'b000001111100;
    localparam logic [11:0] E_LU    = 12'b110000100000;
    localparam logic [11:0] E_FD    = 12'b000001000000;
    localparam logic [11:0] E_DIV   = 12'b111000010010;
    localparam logic [11:0] E_BUSY  = 12'b000000000010;
    localparam logic [11:0] E_DONE  = 12'b000000000001;

    typedef struct packed {
        logic        rst_n;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rte;
        logic        mr;
        logic        mis;
        logic        ds;
        logic        exc;
        logic        ist;
        logic        dst;
        logic [11:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    string       tag_q[$];
    logic [11:0] got;
    logic [11:0] chk_exp;
    string       chk_tag;

    assign got = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW,
                  pc_redirect, div_busy, div_done};

    function automatic vec_t mk(input logic rst_n, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rte, input logic mr, input logic mis,
                                input logic ds, input logic exc, input logic ist,
                                input logic dst, input logic [11:0] exp);
        vec_t v;
        v.rst_n = rst_n; v.rs = rs; v.rt = rt; v.rte = rte; v.mr = mr; v.mis = mis;
        v.ds = ds; v.exc = exc; v.ist = ist; v.dst = dst; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic drive(input vec_t v, input string tag);
        resetn = v.rst_n; rsD = v.rs; rtD = v.rt; rtE = v.rte;
        mem_readE = v.mr; mispredictE = v.mis; div_startE = v.ds;
        except_M = v.exc; i_stall = v.ist; d_stall = v.dst;
        exp_q.push_back(v.exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk_exp = exp_q.pop_front();
            chk_tag = tag_q.pop_front();
            checks++;
            if (got !== chk_exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", chk_tag, got, chk_exp);
            end
            $display("check %s: outputs %b", chk_tag, got);
        end
    end

    vec_t tbl[$];

    initial begin
        resetn = 1'b0; rsD = '0; rtD = '0; rtE = '0;
        mem_readE = 1'b0; mispredictE = 1'b0; div_startE = 1'b0;
        except_M = 1'b0; i_stall = 1'b0; d_stall = 1'b0;

        //                rst rs rt rte mr mis ds exc ist dst expected
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));   // reset
        tbl.push_back(mk(0, 5, 5, 5, 1, 1, 0, 1, 1, 0, E_RST));   // reset overrides all
        tbl.push_back(mk(1, 1, 2, 3, 0, 0, 0, 0, 0, 0, E_NONE));
        tbl.push_back(mk(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, E_LU));    // load-use on rs
        tbl.push_back(mk(1, 5, 0, 5, 0, 0, 0, 0, 0, 0, E_NONE));  // only one cycle
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_NONE));  // rtE=0 never hazards
        tbl.push_back(mk(1, 1, 7, 7, 1, 0, 0, 0, 0, 0, E_LU));    // load-use on rt
        tbl.push_back(mk(1, 8, 9, 7, 1, 0, 0, 0, 0, 0, E_NONE));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_FD));    // plain mispredict
        tbl.push_back(mk(1, 5, 0, 5, 1, 1, 0, 0, 0, 0, E_LU));    // mispredict + load-use
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FD));    // deferred flushD
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL)); // i-cache stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, E_STALL)); // mispredict under stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_STALL));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FD));
        tbl.push_back(mk(1, 5, 0, 5, 1, 0, 0, 0, 1, 0, E_STALL)); // cache beats load-use
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_EXC));   // immediate exception
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        tbl.push_back(mk(1, 5, 0, 5, 1, 1, 0, 1, 0, 0, E_EXC));   // exception wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, E_STALL)); // pending set
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_EXC));   // exception clears it
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_STALL)); // exception under d_stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_STALL)); // EXC_WAIT
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, E_STALL)); // EXC_WAIT
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_STALL)); // EXC_WAIT, cache free
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_EXC));   // EXC_FLUSH
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i], $sformatf("tbl%0d", i));
        end

        // Full division with div_startE held and a mispredict deferred to the done cycle.
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_NONE), "div1_start");
        for (int k = 1; k <= 31; k++) begin
            drive(mk(1, 0, 0, 0, 0, (k == 5), 1, 0, 0, 0, E_DIV), $sformatf("div1_busy%0d", k));
        end
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_DONE | E_FD), "div1_done");
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_NONE), "div1_norestart");
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE), $sformatf("div1_idle%0d", k));
        end

        // Division frozen by a cache stall, then killed by an exception at count 10.
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_NONE), "div2_start");
        for (int k = 1; k <= 23; k++) begin
            if (k == 11) begin
                drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL | E_BUSY), "div2_cstall");
            end else begin
                drive(mk(1, 5, 0, 5, (k == 3), 0, 0, 0, 0, 0, E_DIV), $sformatf("div2_busy%0d", k));
            end
        end
        drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_EXC | E_BUSY), "div2_exc");
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE), $sformatf("div2_after%0d", k));
        end

        // Reset in the middle of a division.
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_NONE), "div3_start");
        for (int k = 1; k <= 5; k++) begin
            drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_DIV), $sformatf("div3_busy%0d", k));
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST), "div3_reset");
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE), "div3_cleared");
        drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_EXC), "div3_idle_exc");
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE), "div3_end");

`ifndef HAZARD_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_tied: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
